muldiv_ctrl: RTL and testbench

Iterative multiply/divide sequencer for the EX stage of the 5-stage pipeline. It accepts MULT/MULTU/DIV/DIVU, runs one radix-2 step per cycle on an internal 64-bit accumulator, and writes the HI/LO register pair. It raises `busy` so the hazard logic can stall MFHI/MFLO and any following mul/div. It runs alongside the single-cycle ALU and does not use the ALU's add/sub path.

---
 rtl/muldiv_pkg.sv | 31 +++
 rtl/muldiv_iter.sv | 41 ++++
 rtl/muldiv_ctrl.sv | 167 ++++++++++++++++
 tb/tb_muldiv_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer.
package muldiv_pkg;

  // Operation encodings as presented on the op port.
  typedef enum logic [1:0] {
    MD_MULTU = 2'b00,
    MD_MULT  = 2'b01,
    MD_DIVU  = 2'b10,
    MD_DIV   = 2'b11
  } md_op_e;

  // Sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_SIGN = 2'b10,
    ST_DONE = 2'b11
  } md_state_e;

  // One radix-2 step per operand bit.
  localparam int MD_STEPS = 32;

  function automatic logic md_is_div(input md_op_e op);
    return (op == MD_DIVU) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_signed(input md_op_e op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Single radix-2 step: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_iter
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0]   i_opnd,
  input  logic               i_div,
  output logic [2*WIDTH-1:0] o_acc
);

  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_rem;
  logic [WIDTH-1:0] w_diff;

  // Next accumulator value for the selected mode.
  always_comb begin
    // Multiply: add multiplicand to the upper half, keeping the carry for the shift.
    w_sum  = {1'b0, i_acc[2*WIDTH-1:WIDTH]} + {1'b0, i_opnd};
    // Divide: partial remainder after the left shift needs one extra bit.
    w_rem  = i_acc[2*WIDTH-1:WIDTH-1];
    // The difference always fits in WIDTH bits when it is taken.
    w_diff = w_rem[WIDTH-1:0] - i_opnd;
    o_acc  = i_acc;
    if (i_div) begin
      if (w_rem >= {1'b0, i_opnd}) begin
        o_acc = {w_diff, i_acc[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = {w_rem[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
      end
    end else begin
      if (i_acc[0]) begin
        o_acc = {w_sum, i_acc[WIDTH-1:1]};
      end else begin
        o_acc = {1'b0, i_acc[2*WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multiply/divide sequencer: FSM, step counter, sign handling and HI/LO registers.
module muldiv_ctrl
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             wr_hi,
  input  logic             wr_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int                CNT_W    = $clog2(MD_STEPS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(MD_STEPS - 1);

  md_state_e          r_state;
  md_state_e          w_next_state;
  md_op_e             r_op;
  md_op_e             w_op_in;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0]   r_opnd;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_res;
  logic               r_neg_rem;
  logic               r_div0;
  logic               r_busy;
  logic               r_done;
  logic               w_in_signed;
  logic               w_in_div;
  logic               w_is_div;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quot;
  logic [WIDTH-1:0]   w_rem;

  assign w_op_in     = md_op_e'(op);
  assign w_in_signed = md_is_signed(w_op_in);
  assign w_in_div    = md_is_div(w_op_in);
  assign w_is_div    = md_is_div(r_op);

  // Signed ops work on magnitudes; 0x80000000 stays 0x80000000 read as unsigned.
  assign w_mag_a = (w_in_signed && src_a[WIDTH-1]) ? -src_a : src_a;
  assign w_mag_b = (w_in_signed && src_b[WIDTH-1]) ? -src_b : src_b;

  // Sign fix-up applied in SIGN; a zero divisor forces an all-ones quotient.
  assign w_prod = r_neg_res ? -r_acc : r_acc;
  assign w_quot = r_div0 ? {WIDTH{1'b1}}
                : (r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0]);
  assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  muldiv_iter #(.WIDTH(WIDTH)) u_iter (
    .i_acc  (r_acc),
    .i_opnd (r_opnd),
    .i_div  (w_is_div),
    .o_acc  (w_acc_next)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: fixed IDLE -> CALC(32) -> SIGN -> DONE sequence.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_next_state = ST_CALC;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_CALC: begin
        if (r_cnt == LAST_CNT) begin
          w_next_state = ST_SIGN;
        end else begin
          w_next_state = ST_CALC;
        end
      end
      ST_SIGN: w_next_state = ST_DONE;
      ST_DONE: w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, result write-back and MTHI/MTLO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op      <= MD_MULTU;
      r_cnt     <= {CNT_W{1'b0}};
      r_acc     <= {(2*WIDTH){1'b0}};
      r_opnd    <= {WIDTH{1'b0}};
      r_hi      <= {WIDTH{1'b0}};
      r_lo      <= {WIDTH{1'b0}};
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_div0    <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_busy <= (w_next_state != ST_IDLE);
      r_done <= (w_next_state == ST_DONE);
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_op      <= w_op_in;
            r_cnt     <= {CNT_W{1'b0}};
            r_acc     <= w_in_div ? {{WIDTH{1'b0}}, w_mag_a} : {{WIDTH{1'b0}}, w_mag_b};
            r_opnd    <= w_in_div ? w_mag_b : w_mag_a;
            r_neg_res <= w_in_signed && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            r_neg_rem <= w_in_signed && src_a[WIDTH-1];
            r_div0    <= w_in_div && (src_b == {WIDTH{1'b0}});
          end else begin
            if (wr_hi) begin
              r_hi <= src_a;
            end
            if (wr_lo) begin
              r_lo <= src_a;
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + 1'b1;
        end
        ST_SIGN: begin
          if (w_is_div) begin
            r_hi <= w_rem;
            r_lo <= w_quot;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
        end
        ST_DONE: begin
          r_cnt <= {CNT_W{1'b0}};
        end
        default: begin
          r_cnt <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases plus random operations.
module tb_muldiv_ctrl;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        wr_hi;
  logic        wr_lo;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] m_hi;
  logic [31:0] m_lo;

  muldiv_ctrl #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .wr_hi (wr_hi),
    .wr_lo (wr_lo),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference result {HI, LO} computed with plain arithmetic.
  function automatic logic [63:0] ref_md(input logic [1:0] o, input logic [31:0] a,
                                         input logic [31:0] b);
    logic signed [63:0] sp;
    int                 sa;
    int                 sb;
    logic [31:0]        q;
    logic [31:0]        r;
    case (o)
      2'b00: return {32'h0, a} * {32'h0, b};
      2'b01: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return sp;
      end
      2'b10: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
      default: begin
        if (b == 32'h0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        sa = a;
        sb = b;
        q  = sa / sb;
        r  = sa % sb;
        return {r, q};
      end
    endcase
  endfunction

  // disturb: 0 none, 1 start pulse during CALC, 2 MTHI during busy, 3 MTLO with start
  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int disturb);
    logic [63:0] exp;
    int          lat;
    exp   = ref_md(o, a, b);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    wr_hi = 1'b0;
    wr_lo = (disturb == 3);
    @(posedge clk); #1;
    start = 1'b0;
    wr_lo = 1'b0;
    check_val("busy_rise", busy, 1'b1);
    check_val("lo_hold", lo, m_lo);
    lat = -1;
    for (int k = 1; k <= 40; k++) begin
      if (disturb == 1 && k == 5) begin
        start = 1'b1;
        op    = 2'($urandom_range(0, 3));
        src_a = $urandom;
        src_b = $urandom;
      end
      if (disturb == 2 && k == 10) begin
        wr_hi = 1'b1;
        src_a = ~m_hi;
      end
      @(posedge clk); #1;
      start = 1'b0;
      wr_hi = 1'b0;
      if (disturb == 2 && k == 10) check_val("mthi_busy", hi, m_hi);
      if (done) begin
        lat = k;
        break;
      end
    end
    check_val("done_lat", lat, 33);
    check_val("res_hi", hi, exp[63:32]);
    check_val("res_lo", lo, exp[31:0]);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    @(posedge clk); #1;
    check_val("done_pulse", done, 1'b0);
    check_val("busy_fall", busy, 1'b0);
  endtask

  initial begin
    int          saw_done;
    logic [31:0] v;
    logic [31:0] ra;
    logic [31:0] rb;
    rst   = 1'b1;
    start = 1'b0;
    op    = 2'b00;
    src_a = 32'h0;
    src_b = 32'h0;
    wr_hi = 1'b0;
    wr_lo = 1'b0;
    m_hi  = 32'h0;
    m_lo  = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_hi", hi, 32'h0);
    check_val("rst_lo", lo, 32'h0);

    // MTHI, MTLO, and both together in IDLE.
    v = 32'hA5A5_1234; wr_hi = 1'b1; src_a = v;
    @(posedge clk); #1; wr_hi = 1'b0;
    check_val("mthi", hi, v); m_hi = v;
    v = 32'h0BAD_F00D; wr_lo = 1'b1; src_a = v;
    @(posedge clk); #1; wr_lo = 1'b0;
    check_val("mtlo", lo, v); m_lo = v;
    v = 32'h1357_9BDF; wr_hi = 1'b1; wr_lo = 1'b1; src_a = v;
    @(posedge clk); #1; wr_hi = 1'b0; wr_lo = 1'b0;
    check_val("mthilo_hi", hi, v);
    check_val("mthilo_lo", lo, v);
    m_hi = v; m_lo = v;

    // Directed corner cases.
    do_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    check_val("multu_max_hi", hi, 32'hFFFF_FFFE);
    do_op(2'b01, 32'hFFFF_FFFD, 32'd7, 0);
    do_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(2'b10, 32'd100, 32'd0, 0);
    do_op(2'b11, 32'hFFFF_FF9C, 32'd0, 0);
    do_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0);
    do_op(2'b00, 32'd12345, 32'd678, 1);
    do_op(2'b10, 32'hDEAD_BEEF, 32'd1000, 2);
    do_op(2'b01, 32'h7FFF_FFFF, 32'hFFFF_FFFE, 3);

    // Reset in the middle of CALC aborts and clears HI/LO.
    start = 1'b1; op = 2'b00; src_a = $urandom; src_b = $urandom;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("abort_busy", busy, 1'b0);
    check_val("abort_done", done, 1'b0);
    check_val("abort_hi", hi, 32'h0);
    check_val("abort_lo", lo, 32'h0);
    m_hi = 32'h0; m_lo = 32'h0;
    saw_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done) saw_done++;
    end
    check_val("abort_no_done", saw_done, 0);
    do_op(2'b00, 32'd6, 32'd7, 0);
    check_val("after_abort_lo", lo, 32'd42);

    // Random operations against the reference model.
    for (int i = 0; i < 16; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'h0;
        1:       rb = 32'($urandom_range(1, 15));
        2:       rb = 32'hFFFF_FFFF;
        default: rb = 32'($urandom);
      endcase
      do_op(2'($urandom_range(0, 3)), ra, rb, 0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
